// File: rtl/axil_stream_master_pkg.sv
// rtl/axil_stream_master_pkg.sv - shared constants and helpers for the AXI-Lite-style stream initiator
// Purpose: default bus widths, command op encoding and the stream slot-free helper.
// Ports: none (package).
package axil_stream_master_pkg;

  // Default widths used by the generated *_axil_* blocks.
  localparam int ADDR_N_DEF = 32;
  localparam int DATA_N_DEF = 32;

  // Command / order-FIFO op encoding.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // A registered stream slot can take a new beat when it is empty or draining this cycle.
  function automatic logic slot_free(input logic valid, input logic ready);
    return !valid || ready;
  endfunction

endpackage

// File: rtl/axil_stream_master_order_fifo.sv
// rtl/axil_stream_master_order_fifo.sv - DEPTH x 1-bit op-order FIFO
// Purpose: remembers the op (read/write) of every accepted command so responses
//          can be steered back in command order.
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   push, din   write one op bit
//   pop         drop the head entry
//   head        op bit at the head (valid when count != 0)
//   count       number of entries held, 0..DEPTH
module axil_stream_master_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointers wrap modulo DEPTH for free because DEPTH is a power of two;
  // full/empty come from count, so the pointers never need an extra bit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axil_stream_master.sv
// rtl/axil_stream_master.sv - single-stream command initiator for split-channel AXI-Lite-style slaves
// Purpose: turns one in-order read/write command stream into RA/WA/W channel beats and
//          merges R/B responses back into one response stream in command order.
// Ports:
//   clk, nrst                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_write, cmd_addr, cmd_data payload
//   sRA, sRA_valid/sRA_ready         read address channel (out)
//   sWA, sWA_valid/sWA_ready         write address channel (out)
//   sW,  sW_valid/sW_ready           write data channel (out)
//   sR,  sR_valid/sR_ready           read data channel (in)
//   sB_valid/sB_ready                write ack, null payload (in)
//   rsp_valid/rsp_ready              response handshake; rsp_data, rsp_write payload
//   outstanding                      accepted commands whose response is not yet delivered
module axil_stream_master
  import axil_stream_master_pkg::*;
#(
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int DATA_N = DATA_N_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_N-1:0]      cmd_addr,
  input  logic [DATA_N-1:0]      cmd_data,
  output logic [ADDR_N-1:0]      sRA,
  output logic                   sRA_valid,
  input  logic                   sRA_ready,
  output logic [ADDR_N-1:0]      sWA,
  output logic                   sWA_valid,
  input  logic                   sWA_ready,
  output logic [DATA_N-1:0]      sW,
  output logic                   sW_valid,
  input  logic                   sW_ready,
  input  logic [DATA_N-1:0]      sR,
  input  logic                   sR_valid,
  output logic                   sR_ready,
  input  logic                   sB_valid,
  output logic                   sB_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_N-1:0]      rsp_data,
  output logic                   rsp_write,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int                 CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);

  logic ra_free;
  logic wa_free;
  logic w_free;
  logic rsp_free;
  logic cmd_fire;
  logic rd_fire;
  logic wr_fire;
  logic r_fire;
  logic b_fire;
  logic fifo_head;
  logic fifo_nonempty;

  assign ra_free  = slot_free(sRA_valid, sRA_ready);
  assign wa_free  = slot_free(sWA_valid, sWA_ready);
  assign w_free   = slot_free(sW_valid, sW_ready);
  assign rsp_free = slot_free(rsp_valid, rsp_ready);

  // Ready is offered speculatively on cmd_write alone; a write needs both its
  // address and data slots so the two channels are always loaded together.
  // A response popping in the same cycle does not free a credit when full.
  assign cmd_ready = nrst && (outstanding < DEPTH_CNT) &&
                     ((cmd_write == OP_WRITE) ? (wa_free && w_free) : ra_free);

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rd_fire  = cmd_fire && (cmd_write == OP_READ);
  assign wr_fire  = cmd_fire && (cmd_write == OP_WRITE);

  // Only the response type matching the oldest command is accepted; the other
  // kind waits on the slave side rather than being dropped.
  assign fifo_nonempty = (outstanding != '0);
  assign sR_ready      = fifo_nonempty && (fifo_head == OP_READ)  && rsp_free;
  assign sB_ready      = fifo_nonempty && (fifo_head == OP_WRITE) && rsp_free;
  assign r_fire        = sR_valid && sR_ready;
  assign b_fire        = sB_valid && sB_ready;

  axil_stream_master_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (cmd_fire),
    .din   (cmd_write),
    .pop   (r_fire || b_fire),
    .head  (fifo_head),
    .count (outstanding)
  );

  // Read address channel.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sRA       <= '0;
      sRA_valid <= 1'b0;
    end else if (rd_fire) begin
      sRA       <= cmd_addr;
      sRA_valid <= 1'b1;
    end else if (sRA_ready) begin
      sRA_valid <= 1'b0;
    end
  end

  // Write address and write data load together but drain independently.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sWA       <= '0;
      sWA_valid <= 1'b0;
    end else if (wr_fire) begin
      sWA       <= cmd_addr;
      sWA_valid <= 1'b1;
    end else if (sWA_ready) begin
      sWA_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sW       <= '0;
      sW_valid <= 1'b0;
    end else if (wr_fire) begin
      sW       <= cmd_data;
      sW_valid <= 1'b1;
    end else if (sW_ready) begin
      sW_valid <= 1'b0;
    end
  end

  // Response register; refilling while the current beat drains keeps one response per cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_write <= 1'b0;
    end else if (r_fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sR;
      rsp_write <= OP_READ;
    end else if (b_fire) begin
      rsp_valid <= 1'b1;
      rsp_data  <= '0;
      rsp_write <= OP_WRITE;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_stream_master.md
Name: axil_stream_master

Overview:
- Initiator side of the split-channel AXI-Lite-style stream bus used by the generated `*_axil_*` blocks. Those blocks have three input channels (read address, write address, write data) and two output channels (read data, null-payload write ack).
- Accepts a single in-order command stream (read or write) and drives the RA/WA/W channels.
- Collects R/B responses and returns them on one response stream in command order.
- Lets firmware-style sequencers and benches talk to any `*_axil_*` block without hand-driving five channels.

Parameters:
- ADDR_N, 32: address width on cmd, RA and WA channels.
- DATA_N, 32: data width on cmd, W, R and rsp channels.
- DEPTH, 4: maximum outstanding commands (order-tracking FIFO depth, power of two, >= 2).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_N  address
- cmd_data  in  DATA_N  write data (ignored for reads)
- sRA, sRA_valid / sRA_ready  out, out / in  ADDR_N, 1 / 1  read address channel
- sWA, sWA_valid / sWA_ready  out, out / in  ADDR_N, 1 / 1  write address channel
- sW, sW_valid / sW_ready  out, out / in  DATA_N, 1 / 1  write data channel
- sR, sR_valid / sR_ready  in, in / out  DATA_N, 1 / 1  read data channel
- sB_valid / sB_ready  in / out  1 / 1  write ack (null stream)
- rsp_valid / rsp_ready  out / in  1 / 1  response stream handshake
- rsp_data  out  DATA_N  read data; 0 for writes
- rsp_write  out  1  1 = write ack, 0 = read data
- outstanding  out  clog2(DEPTH)+1  commands accepted, response not yet delivered

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and nrst.
- Reset: all *_valid = 0; sR_ready = sB_ready = cmd_ready = 0; data regs = 0; outstanding = 0; order FIFO empty. Reset asserted mid-transaction discards all in-flight state. The slave side is reset on the same nrst.
- Fire definition: a handshake fires on a rising clk edge with valid && ready.
- Channel slot free: X slot free = !X_valid || X_ready.
- cmd_ready = nrst && outstanding < DEPTH && (cmd_write ? WA free && W free : RA free). It depends combinationally on cmd_write; cmd_valid is not required. There is no same-cycle credit from a response pop when full.
- Read command fire at cycle N: sRA <= cmd_addr; sRA_valid = 1 from N+1. Push 0 into the order FIFO.
- Write command fire at cycle N: sWA <= cmd_addr and sW <= cmd_data; both valid from N+1. Push 1 into the order FIFO.
- Channel clearing: each channel valid clears independently on its own fire unless it is reloaded in the same cycle. Payload stays stable while valid && !ready.
- sR_ready = FIFO nonempty && head == 0 && rsp slot free.
- sB_ready = FIFO nonempty && head == 1 && rsp slot free.
- A response that does not match the head, or arrives with the FIFO empty, is stalled rather than dropped.
- R fire at M: rsp_data <= sR; rsp_write <= 0; rsp_valid = 1 from M+1; FIFO pops.
- B fire: rsp_data <= 0; rsp_write <= 1; otherwise the same as R fire.
- rsp_valid clears on rsp fire unless it is refilled the same cycle. Back-to-back responses run 1 per cycle when rsp_ready is held high.
- Counter: outstanding increments on cmd fire and decrements on R/B fire. Both in one cycle leaves it unchanged. It never exceeds DEPTH.
- Minimum latency: cmd fire -> channel valid is 1 cycle; R/B fire -> rsp_valid is 1 cycle.
- Order FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH. full/empty is taken from the outstanding count.

Decomposition:
- Shared primitives header holds:
  - stream valid/ready macros;
  - `intN/`addrN defaults feeding DATA_N/ADDR_N;
  - the op encoding constants OP_READ = 0, OP_WRITE = 1.
- One sub-module: `order_fifo`, DEPTH x 1-bit synchronous FIFO with push/pop/head/count and async active-low reset. The top owns the channel registers, the response register and the ready logic.

Test Plan:
- Reset and idle:
  - Assert nrst = 0 mid-burst with 3 outstanding.
  - Required: all valids 0 and outstanding = 0 within the same cycle.
  - After release, first read of 0x10 produces sRA_valid exactly 1 cycle after cmd fire.
- Write-then-read against tests_axil_map_w:
  - Write addr i data i for i = 0..15, then read i = 0..15.
  - Required: 16 rsp with rsp_write = 1 and data 0, then 16 with rsp_write = 0 and rsp_data = i + 3, in order.
- Reordering stall:
  - Issue read 5 then write 6.
  - Slave model asserts sB_valid 4 cycles before sR_valid.
  - Required: sB_ready stays 0 until the read rsp has fired; rsp order is read, write.
- Full:
  - DEPTH = 4, slave withholds R/B.
  - Required: 4 reads accepted, cmd_ready = 0 on the 5th, outstanding = 4.
  - Release one R: outstanding = 3 and the 5th command fires the next cycle.
- Backpressure:
  - rsp_ready random (seed 42), sWA_ready and sW_ready random independently (seed 21), 256 mixed commands.
  - Required: no payload change while valid && !ready; response count = 256; order matches a scoreboard.
- Independent W/WA:
  - sWA_ready = 1, sW_ready = 0 for 3 cycles.
  - Required: sWA_valid drops after 1 cycle, sW_valid holds, and the next write cmd_ready stays 0 until sW fires.
